// File: rtl/imem_program_loader.sv
// Boot-time program loader: streams words into instruction memory while
// holding the core in reset, then releases the core after a short delay.
//
// state   | meaning
// IDLE    | after reset, waiting for a legal start
// LOAD    | accepting stream words and writing them to imem
// RELEASE | last write landing, core still held in reset for RELEASE_DLY cycles
// RUN     | core released; a legal start reloads without a global reset
module imem_program_loader #(
    parameter int N           = 32,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int RELEASE_DLY = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              in_valid,
    input  logic [N-1:0]      in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [N-1:0]      imem_wdata,
    output logic              core_rstn,
    output logic              busy,
    output logic              done,
    output logic              err_len
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [3:0]      DLY_INIT = 4'(RELEASE_DLY);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [3:0]          dly_q, dly_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [N-1:0]        wdata_q, wdata_d;
    logic                core_rstn_q, core_rstn_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_len_q, err_len_d;
    logic                hs;
    logic                len_ok;

    assign in_ready = (state_q == LOAD);
    assign hs       = in_valid && in_ready;
    assign len_ok   = (prog_len != '0) && (prog_len <= DEPTH_L);

    // Next-state, write-port and flag logic; status outputs follow the next state
    // so they are registered yet aligned with the state they describe.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        dly_d     = dly_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_len_d = err_len_q;

        case (state_q)
            IDLE, RUN: begin
                if (start) begin
                    if (len_ok) begin
                        err_len_d = 1'b0;
                        len_d     = prog_len;
                        count_d   = '0;
                        state_d   = LOAD;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (hs) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[ADDR_W-1:0];
                    wdata_d = in_data;
                    count_d = count_q + LEN_ONE;
                    if (count_q == len_q - LEN_ONE) begin
                        state_d = RELEASE;
                        dly_d   = DLY_INIT;
                    end
                end
            end
            RELEASE: begin
                if (dly_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        core_rstn_d = (state_d == RUN);
        done_d      = (state_d == RUN);
        busy_d      = (state_d == LOAD) || (state_d == RELEASE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            count_q     <= '0;
            len_q       <= '0;
            dly_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            core_rstn_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            dly_q       <= dly_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            core_rstn_q <= core_rstn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_len_q   <= err_len_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rstn  = core_rstn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: write log captured by a monitor,
// each scenario task checks its own expectations inline.
module tb_imem_program_loader;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [10:0] prog_len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rstn;
    logic        busy;
    logic        done;
    logic        err_len;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int run_cyc  = -1;
    logic prev_done = 1'b0;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    imem_program_loader #(.N(32), .ADDR_W(10), .DEPTH(1024), .RELEASE_DLY(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .prog_len   (prog_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rstn  (core_rstn),
        .busy       (busy),
        .done       (done),
        .err_len    (err_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: log writes and the cycle done rises, sampled 1 after the edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (done === 1'b1 && !prev_done) run_cyc = cyc;
        prev_done = (done === 1'b1);
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        run_cyc = -1;
    endtask

    task automatic do_start(input logic [10:0] len);
        start    = 1'b1;
        prog_len = len;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic feed(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_assert++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, budget);
        end
    endtask

    task automatic check_writes(input string name, input int n, input logic [31:0] base);
        n_assert++;
        if (wr_addr.size() !== n) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d required %0d", name, wr_addr.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_assert++;
                if (wr_addr[i] !== 10'(i) || wr_data[i] !== base + 32'(i)) begin
                    n_fail++;
                    $display("FAIL %s write[%0d]: got addr=%0d data=%h required addr=%0d data=%h",
                             name, i, wr_addr[i], wr_data[i], i, base + 32'(i));
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_assert++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, core_rstn, busy, done, err_len} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b required all 0",
                     in_ready, imem_we, imem_addr, imem_wdata, core_rstn, busy, done, err_len);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        clear_log();
        do_start(11'd3);
        n_assert++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || core_rstn !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_load_state: got rdy=%b busy=%b crst=%b done=%b required 1 1 0 0",
                     in_ready, busy, core_rstn, done);
        end
        feed(3, 32'hA000_0000);
        n_assert++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_fall: got rdy=%b busy=%b required 0 1", in_ready, busy);
        end
        wait_done(20);
        check_writes("b2b", 3, 32'hA000_0000);
        if (wr_cyc.size() == 3) begin
            n_assert++;
            if (wr_cyc[1] != wr_cyc[0] + 1 || wr_cyc[2] != wr_cyc[1] + 1) begin
                n_fail++;
                $display("FAIL b2b_consecutive: got cycles %0d %0d %0d required consecutive",
                         wr_cyc[0], wr_cyc[1], wr_cyc[2]);
            end
            n_assert++;
            if (run_cyc - wr_cyc[2] != 5) begin
                n_fail++;
                $display("FAIL b2b_release_delay: got %0d cycles after last write required 5",
                         run_cyc - wr_cyc[2]);
            end
        end
        n_assert++;
        if (core_rstn !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_run: got crst=%b done=%b busy=%b required 1 1 0", core_rstn, done, busy);
        end
    endtask

    task automatic test_gaps();
        logic [6:0] pat;
        logic [31:0] exp_d[4];
        int j;
        pat = 7'b1011001;
        clear_log();
        do_start(11'd4);
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            in_data  = 32'hB000_0000 + 32'(i);
            @(negedge clk);
        end
        n_assert++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_ready_after_last: got %b required 0", in_ready);
        end
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        wait_done(20);
        exp_d[0] = 32'hB000_0000;
        exp_d[1] = 32'hB000_0003;
        exp_d[2] = 32'hB000_0004;
        exp_d[3] = 32'hB000_0006;
        n_assert++;
        if (wr_addr.size() !== 4) begin
            n_fail++;
            $display("FAIL gaps_write_count: got %0d required 4", wr_addr.size());
        end else begin
            for (j = 0; j < 4; j++) begin
                n_assert++;
                if (wr_addr[j] !== 10'(j) || wr_data[j] !== exp_d[j]) begin
                    n_fail++;
                    $display("FAIL gaps_write[%0d]: got addr=%0d data=%h required addr=%0d data=%h",
                             j, wr_addr[j], wr_data[j], j, exp_d[j]);
                end
            end
        end
    endtask

    task automatic test_err_len();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        clear_log();
        do_start(11'd0);
        n_assert++;
        if (err_len !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL err_len_zero: got err=%b rdy=%b busy=%b done=%b required 1 0 0 0",
                     err_len, in_ready, busy, done);
        end
        do_start(11'd1025);
        in_valid = 1'b1;
        in_data  = 32'h1111_1111;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        n_assert++;
        if (err_len !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || wr_addr.size() !== 0) begin
            n_fail++;
            $display("FAIL err_len_1025: got err=%b rdy=%b busy=%b writes=%0d required 1 0 0 0",
                     err_len, in_ready, busy, wr_addr.size());
        end
        do_start(11'd2);
        n_assert++;
        if (err_len !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_len_clear: got err=%b rdy=%b required 0 1", err_len, in_ready);
        end
        feed(2, 32'hC100_0000);
        wait_done(20);
        check_writes("err_recover", 2, 32'hC100_0000);
    endtask

    task automatic test_reload();
        clear_log();
        do_start(11'd1025);
        n_assert++;
        if (err_len !== 1'b1 || done !== 1'b1 || core_rstn !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_illegal: got err=%b done=%b crst=%b busy=%b required 1 1 1 0",
                     err_len, done, core_rstn, busy);
        end
        do_start(11'd2);
        n_assert++;
        if (core_rstn !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || err_len !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_enter: got crst=%b done=%b busy=%b err=%b required 0 0 1 0",
                     core_rstn, done, busy, err_len);
        end
        feed(2, 32'hD000_0000);
        wait_done(20);
        check_writes("reload", 2, 32'hD000_0000);
    endtask

    task automatic test_reset_abort();
        clear_log();
        do_start(11'd5);
        feed(2, 32'hE000_0000);
        rstn = 1'b0;
        @(negedge clk);
        n_assert++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, core_rstn, busy, done, err_len} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got rdy=%b we=%b addr=%h data=%h crst=%b busy=%b done=%b err=%b required all 0",
                     in_ready, imem_we, imem_addr, imem_wdata, core_rstn, busy, done, err_len);
        end
        check_writes("abort_partial", 2, 32'hE000_0000);
        rstn = 1'b1;
        @(negedge clk);
        clear_log();
        do_start(11'd5);
        feed(5, 32'hE100_0000);
        wait_done(20);
        check_writes("abort_rewrite", 5, 32'hE100_0000);
    endtask

    task automatic test_full_depth();
        int zeros;
        clear_log();
        do_start(11'd1024);
        feed(1024, 32'hF000_0000);
        wait_done(20);
        check_writes("full", 1024, 32'hF000_0000);
        zeros = 0;
        foreach (wr_addr[i]) if (wr_addr[i] == 10'd0) zeros++;
        n_assert++;
        if (zeros != 1) begin
            n_fail++;
            $display("FAIL full_addr0_once: got %0d writes to addr 0 required 1", zeros);
        end
        n_assert++;
        if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== 10'd1023) begin
            n_fail++;
            $display("FAIL full_last_addr: got %0d writes, last addr %0d required 1023",
                     wr_addr.size(), (wr_addr.size() == 0) ? 0 : int'(wr_addr[wr_addr.size()-1]));
        end
        n_assert++;
        if (done !== 1'b1 || core_rstn !== 1'b1) begin
            n_fail++;
            $display("FAIL full_done: got done=%b crst=%b required 1 1", done, core_rstn);
        end
    endtask

    initial begin
        rstn     = 1'b0;
        start    = 1'b0;
        prog_len = '0;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_gaps();
        test_err_len();
        test_reload();
        test_reset_abort();
        test_full_depth();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Boot-time block upstream of the MIPS core's IF stage.
- Accepts a program as a stream of 32-bit words over a valid/ready interface and writes them into instruction memory through its write port.
- Holds the core in reset via core_rstn while loading, then releases it.
- Allows a host or testbench to reload a program without a global reset.

Parameters:
- N, 32, instruction word width (matches defines::N)
- ADDR_W, 10, instruction memory word-address width
- DEPTH, 1024, instruction memory depth in words; must equal 2**ADDR_W
- RELEASE_DLY, 4, cycles core_rstn stays low after the last write before release; legal range 1..15

Ports:
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse, begins a load
- prog_len  in  ADDR_W+1  number of words to load; sampled on the accepted start
- in_valid  in  1  stream word valid
- in_data  in  N  stream word
- in_ready  out  1  loader can accept a word
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  instruction memory word address
- imem_wdata  out  N  instruction memory write data
- core_rstn  out  1  reset to the MIPS core; 0 holds it in reset
- busy  out  1  high in LOAD and RELEASE
- done  out  1  high in RUN
- err_len  out  1  sticky illegal-length flag

Behaviour:
- Synchronous active-low reset. While rstn=0 at a clock edge: state=IDLE; count, len and delay counter are 0; all outputs are 0, including core_rstn=0 and err_len=0.
- Reset during LOAD or RELEASE aborts the load. Words already written stay in memory; the block erases nothing.
- States are IDLE, LOAD, RELEASE and RUN. All outputs are registered except in_ready, which is decoded from the state: in_ready=1 iff state=LOAD.
- IDLE:
  - start with prog_len=0 or prog_len>DEPTH: err_len<=1 and the state stays IDLE.
  - start with a legal prog_len: err_len<=0, len<=prog_len, count<=0, next state LOAD.
- LOAD:
  - A handshake is in_valid && in_ready. On a handshake, the next cycle has imem_we=1, imem_addr=count[ADDR_W-1:0] and imem_wdata=in_data (1-cycle write latency). count increments.
  - imem_we=0 in any cycle not following a handshake.
  - If the handshake accepts word number len-1, the next state is RELEASE and the delay counter loads RELEASE_DLY. in_ready=0 from the following cycle, so exactly len words are accepted.
  - start is ignored in LOAD and RELEASE.
  - in_valid back-to-back on every cycle is sustained at 1 word per clock.
- RELEASE:
  - The delay counter decrements every cycle. When it reaches 0, the next state is RUN.
  - core_rstn=0 for the whole of RELEASE. The final imem write lands in the first RELEASE cycle.
- RUN:
  - core_rstn=1 and done=1.
  - start with a legal prog_len: core_rstn<=0 and done<=0 on the next edge, state goes to LOAD, count<=0. The core therefore sees reset in the same cycle as the first possible write.
  - start with an illegal prog_len: err_len<=1 and the state stays RUN; the core is undisturbed.
- busy=1 iff state is LOAD or RELEASE. done and busy are never both 1.
- Address wrap cannot occur, because prog_len is limited to DEPTH.
- A prog_len of exactly DEPTH writes addresses 0..DEPTH-1.
- in_data is ignored whenever in_ready=0.

Test Plan:
- Reset, then start with prog_len=3 and three back-to-back words A0,A1,A2 -> exactly 3 imem_we pulses on consecutive cycles, at addr 0,1,2 with the matching data. in_ready falls after the 3rd handshake. core_rstn rises and done=1 exactly RELEASE_DLY(4)+1 cycles after the last write.
- prog_len=4 with in_valid toggled 1,0,0,1,1,0,1 -> writes only on handshakes, at addresses 0..3 in order, with no gaps in addressing. A 5th offered word is not accepted (in_ready=0).
- start with prog_len=0, then prog_len=1025 -> err_len=1, state stays IDLE, in_ready=0, no writes. A following legal start with prog_len=2 clears err_len and loads 2 words.
- In RUN, pulse start with prog_len=2 -> core_rstn=0 and done=0 on the next cycle, busy=1, 2 words written at addr 0,1, then release again.
- Assert rstn=0 for one cycle after 2 of 5 words -> all outputs are 0 and state is IDLE. A subsequent start with prog_len=5 rewrites from addr 0.
- prog_len=1024 with a continuous stream -> 1024 writes, last at addr 1023. No write to addr 0 occurs after the first. done is asserted.
